exec_engine_p: RTL and testbench

Parametrised next-generation execution engine. Fetches 32-bit opcodes from instruction memory, decodes them as operation_dest_src1_src2, reads operands from main memory and executes integer or lane-wise matrix operations internally. Writes the result back to main memory over the shared nRead/nWrite/address bus. Stop halts the engine cleanly with a status flag instead of ending simulation, and unsupported opcodes raise a sticky error.

---
 rtl/exec_engine_p_if.sv | 23 ++
 rtl/exec_engine_p.sv | 211 +++++++++++++++++++++
 tb/tb_exec_engine_p.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_engine_p_if.sv
// rtl/exec_engine_p_if.sv - Shared memory bus between the execution engine and its memories
// master: engine side (drives ExeDataOut/address/nRead/nWrite, receives read data)
// slave : memory side (drives InstructDataOut/MemDataOut)
interface exec_engine_p_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0] InstructDataOut;
  logic [DATA_W-1:0] MemDataOut;
  logic [DATA_W-1:0] ExeDataOut;
  logic [15:0]       address;
  logic              nRead;
  logic              nWrite;

  modport master (
    input  InstructDataOut, MemDataOut,
    output ExeDataOut, address, nRead, nWrite
  );

  modport slave (
    output InstructDataOut, MemDataOut,
    input  ExeDataOut, address, nRead, nWrite
  );
endinterface

// File: rtl/exec_engine_p.sv
// rtl/exec_engine_p.sv - Fetch/decode/execute engine for lane-wise matrix and integer ops
// Ports: Clk, nReset (async, active-low); bus (master side of exec_engine_p_if:
// instruction/main read data in, write data, address, nRead, nWrite out);
// halted (Stop executed), error (sticky unsupported opcode), pc (program counter).
module exec_engine_p #(
  parameter int          DATA_W     = 256,
  parameter int          ELEM_W     = 16,
  parameter int          PC_W       = 8,
  parameter int          RD_LAT     = 2,
  parameter logic [15:0] INSTR_BASE = 16'h8000,
  parameter logic [15:0] MAT_BASE   = 16'h2000,
  parameter logic [15:0] INT_BASE   = 16'h0000
) (
  input  logic            Clk,
  input  logic            nReset,
  exec_engine_p_if.master bus,
  output logic            halted,
  output logic            error,
  output logic [PC_W-1:0] pc
);
  localparam int LANES = DATA_W / ELEM_W;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {FETCH, DECODE, RD1, RD2, EXEC, WRITE, HALT} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       opcode_q, opcode_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0] exe_data_q, exe_data_d, alu_result;
  logic [15:0]       address_q, address_d;
  logic              nread_q, nread_d, nwrite_q, nwrite_d;
  logic              halted_q, halted_d, error_q, error_d;

  logic [7:0]  op, dest_f, src1_f, src2_f;
  logic [15:0] base;
  logic        op_supported;

  // Only the low 32 bits of an instruction word carry the opcode.
  wire unused_instr_bits = ^bus.InstructDataOut[DATA_W-1:32];

  assign {op, dest_f, src1_f, src2_f} = opcode_q;
  assign base   = (op[7:4] == 4'h1) ? INT_BASE : MAT_BASE;
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    case (op)
      8'h01, 8'h02, 8'h04, 8'h05, 8'h10, 8'h11, 8'h12: op_supported = 1'b1;
      default:                                         op_supported = 1'b0;
    endcase
  end

  // Lane-wise datapath; each lane is truncated to ELEM_W so nothing crosses lanes.
  // Scale ops use lane 0 of src2, which holds the immediate for matScaleImm.
  always_comb begin
    logic [ELEM_W-1:0] a, b, s;
    alu_result = '0;
    a = '0;
    b = '0;
    s = src2_q[ELEM_W-1:0];
    for (int i = 0; i < LANES; i++) begin
      a = src1_q[i*ELEM_W +: ELEM_W];
      b = src2_q[i*ELEM_W +: ELEM_W];
      case (op)
        8'h01:        alu_result[i*ELEM_W +: ELEM_W] = a + b;
        8'h02:        alu_result[i*ELEM_W +: ELEM_W] = a - b;
        8'h04, 8'h05: alu_result[i*ELEM_W +: ELEM_W] = a * s;
        8'h10:        if (i == 0) alu_result[i*ELEM_W +: ELEM_W] = a + b;
        8'h11:        if (i == 0) alu_result[i*ELEM_W +: ELEM_W] = a - b;
        8'h12:        if (i == 0) alu_result[i*ELEM_W +: ELEM_W] = a * b;
        default:      ;
      endcase
    end
  end

  // Bus outputs are registered, so every transition loads the values the next
  // phase must present. The only exception is the first cycle after reset, where
  // FETCH sees nRead still high and launches the read itself.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    exe_data_d = exe_data_q;
    address_d  = address_q;
    nread_d    = nread_q;
    nwrite_d   = nwrite_q;
    halted_d   = halted_q;
    error_d    = error_q;
    case (state_q)
      FETCH: begin
        if (nread_q) begin
          nread_d   = 1'b0;
          address_d = INSTR_BASE + 16'(pc_q);
          cnt_d     = '0;
        end else if (cnt_q == CNT_LAST) begin
          opcode_d  = bus.InstructDataOut[31:0];
          nread_d   = 1'b1;
          address_d = '0;
          state_d   = DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECODE: begin
        cnt_d = '0;
        if (op == 8'hFF) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (op_supported) begin
          nread_d   = 1'b0;
          address_d = base + {8'h00, src1_f};
          if (op == 8'h05) src2_d = DATA_W'(src2_f);
          state_d   = RD1;
        end else begin
          error_d   = 1'b1;
          pc_d      = pc_inc;
          nread_d   = 1'b0;
          address_d = INSTR_BASE + 16'(pc_inc);
          state_d   = FETCH;
        end
      end
      RD1: begin
        if (cnt_q == CNT_LAST) begin
          src1_d = bus.MemDataOut;
          cnt_d  = '0;
          if (op == 8'h05) begin
            nread_d   = 1'b1;
            address_d = '0;
            state_d   = EXEC;
          end else begin
            address_d = base + {8'h00, src2_f};
            state_d   = RD2;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD2: begin
        if (cnt_q == CNT_LAST) begin
          src2_d    = bus.MemDataOut;
          cnt_d     = '0;
          nread_d   = 1'b1;
          address_d = '0;
          state_d   = EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        exe_data_d = alu_result;
        nwrite_d   = 1'b0;
        address_d  = base + {8'h00, dest_f};
        state_d    = WRITE;
      end
      WRITE: begin
        exe_data_d = '0;
        nwrite_d   = 1'b1;
        pc_d       = pc_inc;
        nread_d    = 1'b0;
        address_d  = INSTR_BASE + 16'(pc_inc);
        cnt_d      = '0;
        state_d    = FETCH;
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      cnt_q      <= '0;
      opcode_q   <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      exe_data_q <= '0;
      address_q  <= '0;
      nread_q    <= 1'b1;
      nwrite_q   <= 1'b1;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      exe_data_q <= exe_data_d;
      address_q  <= address_d;
      nread_q    <= nread_d;
      nwrite_q   <= nwrite_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
    end
  end

  assign bus.ExeDataOut = exe_data_q;
  assign bus.address    = address_q;
  assign bus.nRead      = nread_q;
  assign bus.nWrite     = nwrite_q;
  assign halted         = halted_q;
  assign error          = error_q;
  assign pc             = pc_q;
endmodule

// File: tb/tb_exec_engine_p.sv
// tb/tb_exec_engine_p.sv - Scoreboard bench for exec_engine_p
module tb_exec_engine_p;
  typedef logic [271:0] wr_t;  // {address, data}

  logic clk = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  logic [31:0]  imem [0:255];
  logic [255:0] dmem [0:511];

  exec_engine_p_if #(.DATA_W(256)) bus_m();
  exec_engine_p_if #(.DATA_W(256)) bus_1();
  exec_engine_p_if #(.DATA_W(256)) bus_4();

  assign bus_m.InstructDataOut = {224'b0, imem[bus_m.address[7:0]]};
  assign bus_m.MemDataOut      = dmem[{bus_m.address[13], bus_m.address[7:0]}];
  assign bus_1.InstructDataOut = {224'b0, imem[bus_1.address[7:0]]};
  assign bus_1.MemDataOut      = dmem[{bus_1.address[13], bus_1.address[7:0]}];
  assign bus_4.InstructDataOut = {224'b0, imem[bus_4.address[7:0]]};
  assign bus_4.MemDataOut      = dmem[{bus_4.address[13], bus_4.address[7:0]}];

  logic       halted_m, error_m, halted_1, error_1, halted_4, error_4;
  logic [7:0] pc_m;
  logic [1:0] pc_1, pc_4;

  exec_engine_p u_main (.Clk(clk), .nReset(rst_m), .bus(bus_m),
                        .halted(halted_m), .error(error_m), .pc(pc_m));
  exec_engine_p #(.RD_LAT(1), .PC_W(2)) u_r1 (.Clk(clk), .nReset(rst_s), .bus(bus_1),
                        .halted(halted_1), .error(error_1), .pc(pc_1));
  exec_engine_p #(.RD_LAT(4), .PC_W(2)) u_r4 (.Clk(clk), .nReset(rst_s), .bus(bus_4),
                        .halted(halted_4), .error(error_4), .pc(pc_4));

  task automatic start_main(output bit ok);
    rst_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_m = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_m.nRead) begin ok = 1'b1; break; end
    end
  endtask

  // Runs the main engine from one fetch start to the next (or to halt),
  // collecting writes into obs_q and counting cycles and read phases.
  task automatic step_instr(output int cyc, output int phases, output int writes,
                            output int overlaps, output bit timeout);
    logic        prev_nr;
    logic [15:0] prev_addr;
    cyc = 0; phases = 1; writes = 0; overlaps = 0; timeout = 1'b0;
    prev_nr = bus_m.nRead;
    prev_addr = bus_m.address;
    forever begin
      @(negedge clk);
      cyc++;
      if (!bus_m.nRead && !bus_m.nWrite) overlaps++;
      if (!bus_m.nWrite) begin
        writes++;
        obs_q.push_back({bus_m.address, bus_m.ExeDataOut});
      end
      if (halted_m) break;
      if (!bus_m.nRead && (prev_nr || bus_m.address != prev_addr)) begin
        if (bus_m.address[15]) break;
        phases++;
      end
      prev_nr = bus_m.nRead;
      prev_addr = bus_m.address;
      if (cyc >= 200) begin timeout = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_m = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_m.nRead !== 1'b1 || bus_m.nWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_strobes: nRead=%b nWrite=%b want 1 1", bus_m.nRead, bus_m.nWrite);
    end
    checks++;
    if (bus_m.address !== 16'h0 || bus_m.ExeDataOut !== 256'h0) begin
      errors++;
      $display("FAIL reset_bus: address=%h data=%h want 0", bus_m.address, bus_m.ExeDataOut);
    end
    checks++;
    if (halted_m !== 1'b0 || error_m !== 1'b0 || pc_m !== 8'h0) begin
      errors++;
      $display("FAIL reset_status: halted=%b error=%b pc=%h want 0 0 0", halted_m, error_m, pc_m);
    end
  endtask

  task automatic test_int_ops();
    bit ok;
    int cyc, ph, wr, ov;
    bit to;
    wr_t got, want;
    imem[0] = 32'h10_05_01_02;
    imem[1] = 32'h11_06_01_02;
    imem[2] = 32'h12_07_03_04;
    dmem[1] = {{15{16'h5A5A}}, 16'd7};
    dmem[2] = {{15{16'hA5A5}}, 16'd9};
    dmem[3] = {{15{16'h1111}}, 16'h0123};
    dmem[4] = {{15{16'h2222}}, 16'h0100};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({16'h0005, 256'h0010});
    exp_q.push_back({16'h0006, 256'hFFFE});
    exp_q.push_back({16'h0007, 256'h2300});
    start_main(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL int_start: no fetch after reset"); end
    checks++;
    if (bus_m.address !== 16'h8000) begin
      errors++; $display("FAIL int_fetch_addr: got %h want 8000", bus_m.address);
    end
    for (int k = 0; k < 3; k++) begin
      step_instr(cyc, ph, wr, ov, to);
      checks++;
      if (to || cyc !== 9) begin
        errors++; $display("FAIL int_cycles[%0d]: got %0d want 9", k, cyc);
      end
      checks++;
      if (ph !== 3 || wr !== 1 || ov !== 0) begin
        errors++; $display("FAIL int_bus[%0d]: phases=%0d writes=%0d overlaps=%0d want 3 1 0", k, ph, wr, ov);
      end
      checks++;
      if (pc_m !== 8'(k + 1)) begin
        errors++; $display("FAIL int_pc[%0d]: got %0d want %0d", k, pc_m, k + 1);
      end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL int_write[%0d]: no write observed", k);
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          errors++; $display("FAIL int_write[%0d]: got %h want %h", k, got, want);
        end
      end
    end
  endtask

  task automatic test_mat_ops();
    bit ok;
    int cyc, ph, wr, ov;
    bit to;
    wr_t got, want;
    logic [255:0] a, b, s1, s2, e_add, e_scale;
    int ecyc[4];
    int eph[4];
    ecyc[0] = 9; ecyc[1] = 9; ecyc[2] = 9; ecyc[3] = 7;
    eph[0] = 3;  eph[1] = 3;  eph[2] = 3;  eph[3] = 2;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16]  = 16'(i * 16'h1111);
      b[i*16 +: 16]  = 16'(16'hF000 + i);
      s1[i*16 +: 16] = 16'(i + 1);
      s2[i*16 +: 16] = (i == 0) ? 16'h0003 : 16'hABCD;
      e_add[i*16 +: 16]   = 16'((i * 32'h1111 + 32'hF000 + i) & 32'hFFFF);
      e_scale[i*16 +: 16] = 16'(3 * (i + 1));
    end
    imem[0] = 32'h02_10_11_12;
    imem[1] = 32'h01_20_21_22;
    imem[2] = 32'h04_30_31_32;
    imem[3] = 32'h05_10_04_03;
    dmem[256 + 8'h11] = {16{16'h0001}};
    dmem[256 + 8'h12] = {16{16'h0003}};
    dmem[256 + 8'h21] = a;
    dmem[256 + 8'h22] = b;
    dmem[256 + 8'h31] = s1;
    dmem[256 + 8'h32] = s2;
    dmem[256 + 8'h04] = {16{16'h6000}};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({16'h2010, {16{16'hFFFE}}});
    exp_q.push_back({16'h2020, e_add});
    exp_q.push_back({16'h2030, e_scale});
    exp_q.push_back({16'h2010, {16{16'h2000}}});
    start_main(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mat_start: no fetch after reset"); end
    for (int k = 0; k < 4; k++) begin
      step_instr(cyc, ph, wr, ov, to);
      checks++;
      if (to || cyc !== ecyc[k]) begin
        errors++; $display("FAIL mat_cycles[%0d]: got %0d want %0d", k, cyc, ecyc[k]);
      end
      checks++;
      if (ph !== eph[k] || wr !== 1 || ov !== 0) begin
        errors++; $display("FAIL mat_bus[%0d]: phases=%0d writes=%0d overlaps=%0d want %0d 1 0", k, ph, wr, ov, eph[k]);
      end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL mat_write[%0d]: no write observed", k);
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          errors++; $display("FAIL mat_write[%0d]: got %h want %h", k, got, want);
        end
      end
    end
  endtask

  task automatic test_error_stop();
    bit ok;
    int cyc, ph, wr, ov, bad;
    bit to;
    imem[0] = 32'h03_01_02_03;
    imem[1] = 32'hFF_00_00_00;
    obs_q.delete();
    start_main(ok);
    checks++;
    if (!ok || error_m !== 1'b0) begin
      errors++; $display("FAIL err_start: ok=%b error=%b want 1 0", ok, error_m);
    end
    step_instr(cyc, ph, wr, ov, to);
    checks++;
    if (to || cyc !== 3 || wr !== 0) begin
      errors++; $display("FAIL err_cycles: cycles=%0d writes=%0d want 3 0", cyc, wr);
    end
    checks++;
    if (error_m !== 1'b1 || pc_m !== 8'd1 || halted_m !== 1'b0) begin
      errors++; $display("FAIL err_status: error=%b pc=%0d halted=%b want 1 1 0", error_m, pc_m, halted_m);
    end
    step_instr(cyc, ph, wr, ov, to);
    checks++;
    if (to || cyc !== 3 || halted_m !== 1'b1) begin
      errors++; $display("FAIL stop_cycles: cycles=%0d halted=%b want 3 1", cyc, halted_m);
    end
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_m.nRead !== 1'b1 || bus_m.nWrite !== 1'b1 || pc_m !== 8'd1 ||
          halted_m !== 1'b1 || error_m !== 1'b1 || bus_m.ExeDataOut !== 256'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL halt_hold: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int cyc, ph, wr, ov;
    bit to;
    imem[0] = 32'h10_05_01_02;
    imem[1] = 32'h01_20_21_22;
    obs_q.delete();
    start_main(ok);
    step_instr(cyc, ph, wr, ov, to);
    checks++;
    if (!ok || to || pc_m !== 8'd1) begin
      errors++; $display("FAIL midop_pre: ok=%b timeout=%b pc=%0d want 1 0 1", ok, to, pc_m);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus_m.nRead !== 1'b0 || bus_m.address !== 16'h2022) begin
      errors++; $display("FAIL midop_rd2: nRead=%b address=%h want 0 2022", bus_m.nRead, bus_m.address);
    end
    #2 rst_m = 1'b0;
    #1;
    checks++;
    if (bus_m.nRead !== 1'b1 || bus_m.nWrite !== 1'b1 || bus_m.address !== 16'h0 ||
        bus_m.ExeDataOut !== 256'h0 || pc_m !== 8'h0 || halted_m !== 1'b0 || error_m !== 1'b0) begin
      errors++;
      $display("FAIL midop_async: nRead=%b nWrite=%b address=%h pc=%0d want 1 1 0000 0",
               bus_m.nRead, bus_m.nWrite, bus_m.address, pc_m);
    end
    @(negedge clk);
    rst_m = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_m.nRead) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || bus_m.address !== 16'h8000) begin
      errors++; $display("FAIL midop_restart: ok=%b address=%h want 1 8000", ok, bus_m.address);
    end
  endtask

  task automatic test_sweep();
    int f1_cyc[$], f4_cyc[$], f1_pc[$], f4_pc[$];
    logic p1, p4;
    int ov;
    wr_t got, want;
    rst_m = 1'b0;
    for (int k = 0; k < 4; k++) imem[k] = {8'h10, 8'(8'h40 + k), 8'h01, 8'h02};
    dmem[1] = 256'd7;
    dmem[2] = 256'd9;
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back({16'(16'h0040 + (k % 4)), 256'd16});
    rst_s = 1'b0;
    repeat (2) @(negedge clk);
    rst_s = 1'b1;
    p1 = 1'b1; p4 = 1'b1; ov = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (!bus_1.nRead && p1 && bus_1.address[15]) begin f1_cyc.push_back(c); f1_pc.push_back(int'(pc_1)); end
      if (!bus_4.nRead && p4 && bus_4.address[15]) begin f4_cyc.push_back(c); f4_pc.push_back(int'(pc_4)); end
      if (!bus_1.nWrite && obs_q.size() < 5) obs_q.push_back({bus_1.address, bus_1.ExeDataOut});
      if ((!bus_1.nRead && !bus_1.nWrite) || (!bus_4.nRead && !bus_4.nWrite)) ov++;
      p1 = bus_1.nRead;
      p4 = bus_4.nRead;
    end
    checks++;
    if (f1_cyc.size() < 6 || f4_cyc.size() < 6 || ov !== 0) begin
      errors++;
      $display("FAIL sweep_fetches: r1=%0d r4=%0d overlaps=%0d want >=6 >=6 0", f1_cyc.size(), f4_cyc.size(), ov);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (f1_cyc[k+1] - f1_cyc[k] !== 6 || f4_cyc[k+1] - f4_cyc[k] !== 15) begin
          errors++;
          $display("FAIL sweep_cycles[%0d]: r1=%0d r4=%0d want 6 15", k, f1_cyc[k+1] - f1_cyc[k], f4_cyc[k+1] - f4_cyc[k]);
        end
        checks++;
        if (f1_pc[k] !== (k % 4) || f4_pc[k] !== (k % 4)) begin
          errors++;
          $display("FAIL sweep_pc[%0d]: r1=%0d r4=%0d want %0d", k, f1_pc[k], f4_pc[k], k % 4);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL sweep_write[%0d]: no write observed", k);
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          errors++; $display("FAIL sweep_write[%0d]: got %h want %h", k, got, want);
        end
      end
    end
    rst_s = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hFF_00_00_00;
    for (int i = 0; i < 512; i++) dmem[i] = '0;
    rst_s = 1'b0;
    test_reset();
    test_int_ops();
    test_mat_ops();
    test_error_stop();
    test_reset_midop();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
